// File: rtl/decode_scoreboard_if.sv
// Decode/scoreboard bundle: issue request, writeback completion, flush and registered decode result.
// Latency: none (wires only); stall is combinational from the slave, out_* registered in the slave.
// Backpressure: slave raises stall to hold the presented instruction; master keeps it steady until accepted.
interface decode_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_rd_we;
    logic [15:0]       in_imm;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic              flush;
    logic              stall;
    logic              out_valid;
    logic [ADDR_W-1:0] out_rs1;
    logic [ADDR_W-1:0] out_rs2;
    logic [ADDR_W-1:0] out_rd;
    logic              out_rd_we;
    logic [DATA_W-1:0] out_imm_sext;
    logic [NUM_REGS-1:0] pending;
    logic              err_underflow;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_imm,
        output wb_we, wb_addr, flush,
        input  stall, out_valid, out_rs1, out_rs2, out_rd, out_rd_we, out_imm_sext,
        input  pending, err_underflow
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_imm,
        input  wb_we, wb_addr, flush,
        output stall, out_valid, out_rs1, out_rs2, out_rd, out_rd_we, out_imm_sext,
        output pending, err_underflow
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Decode stage register scoreboard: per-register outstanding-write counters gate instruction issue.
// Latency: one cycle from accept to out_valid; stall is combinational in the presentation cycle.
// Backpressure: stall holds the presented instruction on a RAW hazard or a saturated destination counter.
module decode_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int PEND_W   = 2
) (
    input logic clk,
    input logic reset,
    decode_scoreboard_if.slave sb
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    // Counters span the full address space so any address indexes safely;
    // entries for register 0 and addresses >= NUM_REGS are never written.
    logic [PEND_W-1:0] cnt [DEPTH];
    logic [DEPTH-1:0]  tracked;
    logic [DEPTH-1:0]  inc_vec;
    logic [DEPTH-1:0]  dec_vec;
    logic [NUM_REGS-1:0] pend;
    logic rs1_haz, rs2_haz, rd_full, stall_c, accept, inc_ok, wb_ok;

    // Mask of addresses that own a real counter.
    always_comb begin
        tracked = '0;
        for (int i = 1; i < DEPTH; i++) begin
            tracked[i] = (i < NUM_REGS);
        end
    end

    // Hazard detection with write-through bypass on the last outstanding write.
    always_comb begin
        rs1_haz = tracked[sb.in_rs1] && (cnt[sb.in_rs1] != '0) &&
                  !((cnt[sb.in_rs1] == CNT_ONE) && sb.wb_we && (sb.wb_addr == sb.in_rs1));
        rs2_haz = tracked[sb.in_rs2] && (cnt[sb.in_rs2] != '0) &&
                  !((cnt[sb.in_rs2] == CNT_ONE) && sb.wb_we && (sb.wb_addr == sb.in_rs2));
        rd_full = sb.in_rd_we && tracked[sb.in_rd] && (cnt[sb.in_rd] == CNT_MAX) &&
                  !(sb.wb_we && (sb.wb_addr == sb.in_rd));
        stall_c = sb.in_valid && !sb.flush && !reset && (rs1_haz || rs2_haz || rd_full);
        accept  = sb.in_valid && !stall_c && !sb.flush;
        inc_ok  = accept && sb.in_rd_we && tracked[sb.in_rd];
        wb_ok   = sb.wb_we && tracked[sb.wb_addr] && !sb.flush;
    end

    // One-hot increment/decrement requests; decrement only from a nonzero count.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc_ok) begin
            inc_vec[sb.in_rd] = 1'b1;
        end
        if (wb_ok && (cnt[sb.wb_addr] != '0)) begin
            dec_vec[sb.wb_addr] = 1'b1;
        end
    end

    // Counter update; a simultaneous increment and decrement cancel out.
    always_ff @(posedge clk) begin
        if (reset || sb.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // Sticky underflow: writeback to a tracked register with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb.err_underflow <= 1'b0;
        end else if (wb_ok && (cnt[sb.wb_addr] == '0)) begin
            sb.err_underflow <= 1'b1;
        end
    end

    // Decode output register; fields hold their last values when nothing is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb.out_valid    <= 1'b0;
            sb.out_rs1      <= '0;
            sb.out_rs2      <= '0;
            sb.out_rd       <= '0;
            sb.out_rd_we    <= 1'b0;
            sb.out_imm_sext <= '0;
        end else begin
            sb.out_valid <= accept;
            if (accept) begin
                sb.out_rs1      <= sb.in_rs1;
                sb.out_rs2      <= sb.in_rs2;
                sb.out_rd       <= sb.in_rd;
                sb.out_rd_we    <= sb.in_rd_we;
                sb.out_imm_sext <= {{(DATA_W-16){sb.in_imm[15]}}, sb.in_imm};
            end
        end
    end

    // Pending view: one bit per architectural register, bit 0 tied low.
    always_comb begin
        pend = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            pend[i] = (cnt[i] != '0);
        end
    end

    assign sb.pending = pend;
    assign sb.stall   = stall_c;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Testbench for decode_scoreboard: directed scenarios followed by randomized traffic.
// Latency: checks stall mid-cycle, registered outputs 1 time unit after each rising edge.
// Backpressure: reference model decides stall from outstanding-write counts per register.
module tb_decode_scoreboard;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_scoreboard_if #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) sb ();

    decode_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .PEND_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    // Reference model: outstanding write count per register, plus the decode result.
    int          m_cnt [NR];
    bit          m_err;
    bit          m_ov;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    bit          m_rdwe;
    logic [DW-1:0] m_imm;
    int          passed = 0;
    int          total  = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit haz(input int src);
        return (src != 0) && (m_cnt[src] > 0) &&
               !((m_cnt[src] == 1) && sb.wb_we && (int'(sb.wb_addr) == src));
    endfunction

    function automatic bit exp_stall();
        int rd;
        bit full;
        if (reset || sb.flush || !sb.in_valid) return 1'b0;
        rd   = int'(sb.in_rd);
        full = sb.in_rd_we && (rd != 0) && (m_cnt[rd] == 3) &&
               !(sb.wb_we && (int'(sb.wb_addr) == rd));
        return haz(int'(sb.in_rs1)) || haz(int'(sb.in_rs2)) || full;
    endfunction

    function automatic logic [NR-1:0] exp_pending();
        logic [NR-1:0] p;
        p = '0;
        for (int i = 1; i < NR; i++) p[i] = (m_cnt[i] > 0);
        return p;
    endfunction

    task automatic model_update(input bit st);
        bit acc;
        int wa, rd;
        if (reset) begin
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            m_err = 0; m_ov = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rdwe = 0; m_imm = '0;
        end else if (sb.flush) begin
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            m_ov = 0;
        end else begin
            acc = sb.in_valid && !st;
            wa  = int'(sb.wb_addr);
            rd  = int'(sb.in_rd);
            if (sb.wb_we && wa != 0) begin
                if (m_cnt[wa] == 0) m_err = 1;
                else m_cnt[wa] = m_cnt[wa] - 1;
            end
            if (acc && sb.in_rd_we && rd != 0) m_cnt[rd] = m_cnt[rd] + 1;
            m_ov = acc;
            if (acc) begin
                m_rs1 = sb.in_rs1; m_rs2 = sb.in_rs2; m_rd = sb.in_rd; m_rdwe = sb.in_rd_we;
                m_imm = DW'($signed(sb.in_imm));
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", sb.out_valid, m_ov);
        chk("out_rs1", sb.out_rs1, m_rs1);
        chk("out_rs2", sb.out_rs2, m_rs2);
        chk("out_rd", sb.out_rd, m_rd);
        chk("out_rd_we", sb.out_rd_we, m_rdwe);
        chk("out_imm_sext", sb.out_imm_sext, m_imm);
        chk("pending", sb.pending, exp_pending());
        chk("err_underflow", sb.err_underflow, m_err);
    endtask

    task automatic half_a();
        @(negedge clk);
        chk("stall", sb.stall, exp_stall());
    endtask

    task automatic half_b();
        bit st;
        st = exp_stall();
        @(posedge clk);
        model_update(st);
        #1;
        check_outputs();
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit we,
                         input logic [15:0] imm, input bit wbwe, input int wba, input bit fl);
        sb.in_valid = v;
        sb.in_rs1   = AW'(rs1);
        sb.in_rs2   = AW'(rs2);
        sb.in_rd    = AW'(rd);
        sb.in_rd_we = we;
        sb.in_imm   = imm;
        sb.wb_we    = wbwe;
        sb.wb_addr  = AW'(wba);
        sb.flush    = fl;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_err = 0; m_ov = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rdwe = 0; m_imm = '0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 16'h0, 0, 0, 0);
        step();
        step();
        chk("rst_out_valid", sb.out_valid, 0);
        chk("rst_pending", sb.pending, 0);
        chk("rst_imm", sb.out_imm_sext, 0);
        chk("rst_err", sb.err_underflow, 0);
        reset = 1'b0;

        // RAW hazard on r5 resolved by same-cycle writeback bypass.
        drive(1, 0, 0, 5, 1, 16'h0001, 0, 0, 0); step();
        drive(1, 5, 0, 0, 0, 16'h0002, 0, 0, 0); half_a();
        chk("s32_stall", sb.stall, 1);
        chk("s32_pend5", sb.pending[5], 1);
        half_b();
        drive(1, 5, 0, 0, 0, 16'h0002, 1, 5, 0); half_a();
        chk("s32_bypass_stall", sb.stall, 0);
        half_b();
        chk("s32_pend5_clr", sb.pending[5], 0);
        chk("s32_out_valid", sb.out_valid, 1);

        // Saturating r7 counter; a fourth issue waits unless r7 retires the same cycle.
        repeat (3) begin
            drive(1, 0, 0, 7, 1, 16'h0010, 0, 0, 0); step();
        end
        drive(1, 0, 0, 7, 1, 16'h0011, 0, 0, 0); half_a();
        chk("s33_full_stall", sb.stall, 1);
        half_b();
        chk("s33_no_accept", sb.out_valid, 0);
        drive(1, 0, 0, 7, 1, 16'h0011, 1, 7, 0); half_a();
        chk("s33_wb_stall", sb.stall, 0);
        half_b();
        chk("s33_accepted", sb.out_valid, 1);
        repeat (3) begin
            drive(0, 0, 0, 0, 0, 16'h0, 1, 7, 0); step();
        end
        chk("s33_drained", sb.pending[7], 0);
        chk("s33_no_err", sb.err_underflow, 0);

        // Immediate sign extension.
        drive(1, 0, 0, 0, 0, 16'h8001, 0, 0, 0); step();
        chk("s34_neg", sb.out_imm_sext, 32'hFFFF8001);
        chk("s34_valid", sb.out_valid, 1);
        drive(1, 0, 0, 0, 0, 16'h7FFF, 0, 0, 0); step();
        chk("s34_pos", sb.out_imm_sext, 32'h00007FFF);

        // Register 0 never tracked.
        drive(1, 0, 0, 0, 1, 16'h0003, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 16'h0004, 0, 0, 0); half_a();
        chk("s36_stall", sb.stall, 0);
        half_b();
        chk("s36_pending", sb.pending, 0);

        // Flush with a presented instruction.
        drive(1, 0, 0, 3, 1, 16'h0005, 0, 0, 0); step();
        drive(1, 0, 0, 4, 1, 16'h0006, 0, 0, 0); step();
        chk("s37_pend34", sb.pending, 32'h0000_0018);
        drive(1, 3, 4, 5, 1, 16'h0007, 0, 0, 1); half_a();
        chk("s37_flush_stall", sb.stall, 0);
        half_b();
        chk("s37_flush_pend", sb.pending, 0);
        chk("s37_flush_valid", sb.out_valid, 0);

        // Underflow is sticky through flush.
        drive(0, 0, 0, 0, 0, 16'h0, 1, 9, 0); step();
        chk("s35_err", sb.err_underflow, 1);
        drive(0, 0, 0, 0, 0, 16'h0, 0, 0, 1); step();
        chk("s35_err_flush", sb.err_underflow, 1);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, 16'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 40) == 0);
            reset = ($urandom_range(0, 80) == 0);
            step();
            reset = 1'b0;
        end

        // Reset in the middle of a stall.
        drive(0, 0, 0, 0, 0, 16'h0, 0, 0, 1); step();
        drive(1, 0, 0, 6, 1, 16'h1234, 0, 0, 0); step();
        drive(1, 6, 0, 0, 0, 16'h5678, 0, 0, 0); half_a();
        chk("s37_mid_stall", sb.stall, 1);
        half_b();
        reset = 1'b1;
        half_a();
        chk("s37_rst_stall", sb.stall, 0);
        half_b();
        reset = 1'b0;
        chk("s37_rst_valid", sb.out_valid, 0);
        chk("s37_rst_pending", sb.pending, 0);
        chk("s37_rst_rd", sb.out_rd, 0);
        chk("s37_rst_imm", sb.out_imm_sext, 0);
        chk("s37_rst_err", sb.err_underflow, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
